// File: rtl/yukle_kaydet_birimi.sv
// RV32I load/store initiator between the core and the word-addressed data memory.
// One request at a time: byte-lane extract on loads, read-modify-write on sub-word stores.
module yukle_kaydet_birimi #(
    parameter int BELLEK_BAYT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        istek_gecerli,
    output logic        istek_hazir,
    input  logic        istek_yaz,
    input  logic [1:0]  istek_boyut,
    input  logic        istek_isaretsiz,
    input  logic [31:0] istek_adres,
    input  logic [31:0] istek_veri,
    output logic        sonuc_gecerli,
    output logic [31:0] sonuc_veri,
    output logic        hata,
    output logic        bel_oku_aktif,
    output logic        bel_yaz_aktif,
    output logic [31:0] bel_adres,
    output logic [31:0] bel_yaz_veri,
    input  logic [31:0] bel_oku_veri
);

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] OKU   = 2'd1;
    localparam logic [1:0] YAZ   = 2'd2;
    localparam logic [1:0] YANIT = 2'd3;

    logic [1:0]  durum_r;
    logic        yaz_r;
    logic [1:0]  boyut_r;
    logic        isaretsiz_r;
    logic [31:0] adres_r;
    logic [15:0] veri_r;
    logic [31:0] yaz_veri_r;
    logic [31:0] sonuc_veri_r;
    logic        hata_r;
    logic        boy_hata_s;
    logic        aralik_disi_s;
    logic        hata_s;

    function automatic logic [31:0] cikar(input logic [31:0] kelime, input logic [1:0] boyut,
                                          input logic [1:0] ofs, input logic isaretsiz);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] s;
        b = kelime[{ofs, 3'b000} +: 8];
        h = ofs[1] ? kelime[31:16] : kelime[15:0];
        case (boyut)
            2'b00:   s = {{24{b[7] & ~isaretsiz}}, b};
            2'b01:   s = {{16{h[15] & ~isaretsiz}}, h};
            default: s = kelime;
        endcase
        return s;
    endfunction

    // Only the addressed lane is replaced; the rest comes from the word read in OKU.
    function automatic logic [31:0] birlestir(input logic [31:0] kelime, input logic [15:0] veri,
                                              input logic [1:0] boyut, input logic [1:0] ofs);
        logic [31:0] s;
        s = kelime;
        case (boyut)
            2'b00: s[{ofs, 3'b000} +: 8] = veri[7:0];
            2'b01: begin
                if (ofs[1]) begin
                    s[31:16] = veri;
                end else begin
                    s[15:0] = veri;
                end
            end
            default: s = kelime;
        endcase
        return s;
    endfunction

    // Request error classification: alignment, illegal size and range.
    always_comb begin
        boy_hata_s = 1'b0;
        case (istek_boyut)
            2'b00:   boy_hata_s = 1'b0;
            2'b01:   boy_hata_s = istek_adres[0];
            2'b10:   boy_hata_s = |istek_adres[1:0];
            default: boy_hata_s = 1'b1;
        endcase
        aralik_disi_s = (istek_adres >= 32'(BELLEK_BAYT));
        hata_s = boy_hata_s | aralik_disi_s;
    end

    // Request sequencing FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum_r      <= BOSTA;
            yaz_r        <= 1'b0;
            boyut_r      <= 2'b00;
            isaretsiz_r  <= 1'b0;
            adres_r      <= 32'h0;
            veri_r       <= 16'h0;
            yaz_veri_r   <= 32'h0;
            sonuc_veri_r <= 32'h0;
            hata_r       <= 1'b0;
        end else begin
            case (durum_r)
                BOSTA: begin
                    if (istek_gecerli) begin
                        yaz_r       <= istek_yaz;
                        boyut_r     <= istek_boyut;
                        isaretsiz_r <= istek_isaretsiz;
                        adres_r     <= istek_adres;
                        veri_r      <= istek_veri[15:0];
                        hata_r      <= hata_s;
                        if (hata_s) begin
                            sonuc_veri_r <= 32'h0;
                            durum_r      <= YANIT;
                        end else if (istek_yaz && (istek_boyut == 2'b10)) begin
                            yaz_veri_r <= istek_veri;
                            durum_r    <= YAZ;
                        end else begin
                            durum_r <= OKU;
                        end
                    end else begin
                        durum_r <= BOSTA;
                    end
                end
                OKU: begin
                    if (yaz_r) begin
                        yaz_veri_r <= birlestir(bel_oku_veri, veri_r, boyut_r, adres_r[1:0]);
                        durum_r    <= YAZ;
                    end else begin
                        sonuc_veri_r <= cikar(bel_oku_veri, boyut_r, adres_r[1:0], isaretsiz_r);
                        durum_r      <= YANIT;
                    end
                end
                YAZ: begin
                    sonuc_veri_r <= 32'h0;
                    durum_r      <= YANIT;
                end
                YANIT: begin
                    hata_r  <= 1'b0;
                    durum_r <= BOSTA;
                end
                default: durum_r <= BOSTA;
            endcase
        end
    end

    // Strobes and handshake are state decodes gated by rst so no access escapes a reset cycle.
    always_comb begin
        istek_hazir   = (durum_r == BOSTA) & ~rst;
        bel_oku_aktif = (durum_r == OKU) & ~rst;
        bel_yaz_aktif = (durum_r == YAZ) & ~rst;
        sonuc_gecerli = (durum_r == YANIT) & ~rst;
        hata          = (durum_r == YANIT) & hata_r & ~rst;
        bel_adres     = {adres_r[31:2], 2'b00};
        bel_yaz_veri  = yaz_veri_r;
        sonuc_veri    = sonuc_veri_r;
    end

endmodule
